pipelined_barrel_shifter: RTL and testbench
===========================================

# pipelined_barrel_shifter

Multi-mode barrel shifter for the datapath: rotate left/right, logical shift left/right and arithmetic shift right. The mux network is split into registered pipeline segments, with a valid/ready handshake and a sideband tag. It is the parametrised successor of the single-mode combinational rotator, for callers that need backpressure, a shift direction and a bounded logic depth per cycle.

## Interface
- DW, 8: data width in bits.
- MAX_SHIFT, DW-1: largest shift amount; sets the number of mux levels, LVLS = $clog2(MAX_SHIFT+1).
- LVL_PER_REG, 1: mux levels per registered segment; NSEG = ceil(LVLS/LVL_PER_REG).
- TAG_W, 4: width of the sideband tag carried alongside the data.

- clk  in  1  sole clock; rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid_i  in  1  input operation valid.
- in_ready_o  out  1  block accepts an input this cycle.
- in_data_i  in  DW  operand.
- in_amt_i  in  $clog2(MAX_SHIFT+1)  shift magnitude, weighted binary.
- in_mode_i  in  3  operation select: 000 ROL, 001 ROR, 010 SLL, 011 SRL, 100 SRA; 101–111 reserved.
- in_tag_i  in  TAG_W  opaque tag, returned unchanged.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts the result.
- out_data_o  out  DW  result.
- out_tag_o  out  TAG_W  tag of the result.
- out_zero_o  out  1  result is all-zero; present only with SHIFTER_ZERO_FLAG_EN.

## Operation
- Mux level s applies a shift of 2^s when amt[s]=1. Segment k holds levels k*LVL_PER_REG .. min((k+1)*LVL_PER_REG, LVLS)-1.
- Each segment register holds: valid, partial data, amt, mode, tag, and the sign bit of the original operand.
- ROL: bit b of the result takes bit (b-n) mod DW. ROR: bit b takes bit (b+n) mod DW.
- SLL zero-fills on the LSB side. SRL zero-fills on the MSB side.
- SRA fills with the original operand's bit DW-1, not the bit of the partial result.
- An amount of 0 returns the operand unchanged in every mode.
- Reserved modes behave as amount 0: data passes through unchanged.
- Order is strictly in-order. No operation is dropped, duplicated or reordered.
- MAX_SHIFT >= DW, or MAX_SHIFT < 1, is a fatal elaboration error.

## Timing
- Latency is NSEG cycles from the input handshake to out_valid_o. The default configuration (DW=8, LVL_PER_REG=1) gives 3 cycles.
- Throughput is one operation per cycle while out_ready_i=1.
- Segment k advances when its downstream register is empty or is itself advancing. Bubbles collapse, so a gap in the pipeline is filled while the output is stalled.
- in_ready_o = !rst && (segment 0 empty || segment 0 advancing). This is combinational from out_ready_i through the advance chain.
- Input handshake: in_valid_i && in_ready_o. Output handshake: out_valid_o && out_ready_i.
- While out_valid_o=1 and out_ready_i=0, the out_* signals hold stable.
- Reset values: every segment valid=0, data/tag/amt/mode=0, out_valid_o=0, out_data_o=0, out_tag_o=0, out_zero_o=0.
- Reset asserted mid-operation: all in-flight operations are discarded on that edge. Outputs show reset values from the next cycle.
- A simultaneous input handshake and reset is ignored.
- Simultaneous input and output handshakes on a full pipeline are legal and keep it full.
- No combinational path from in_* to out_*.

## Configuration
- SHIFTER_ZERO_FLAG_EN defined:
  - out_zero_o exists.
  - It equals (final segment data == 0), registered with the data and stable under stall.
- SHIFTER_ZERO_FLAG_EN undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- DW=8, amount 1, mode ROL, operand 0x81 -> 0x03. Same operand and amount, mode ROR -> 0xC0. Each appears 3 cycles after its input handshake.
- DW=8, operand 0x81, amount 3: SLL -> 0x08, SRL -> 0x10, SRA -> 0xF0.
  - SRA on 0x41, amount 3 -> 0x08.
  - Amount 0 in any mode -> 0x81.
  - Mode 110, amount 5 -> 0x81.
- Back-to-back stream of 10 operations with tags 0..9 and out_ready_i=1 -> one result per cycle, tags in order 0..9.
- Hold out_ready_i=0 for 5 cycles while driving inputs:
  - Exactly 3 operations are accepted, then in_ready_o=0.
  - out_* stays stable throughout.
  - On release, all results are delivered in order with no loss.
- Assert rst for 1 cycle with 3 operations in flight:
  - out_valid_o=0 and out_data_o=0 the next cycle.
  - in_ready_o=1 once rst is low.
  - None of the flushed tags ever appears at the output.
- With SHIFTER_ZERO_FLAG_EN: SLL 0x81 by 7 -> 0x80, out_zero_o=0. SRL 0x01 by 1 -> 0x00, out_zero_o=1.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined multi-mode barrel shifter (ROL/ROR/SLL/SRL/SRA) with valid/ready and sideband tag.
// Latency NSEG cycles; bubbles collapse under stall. `SHIFTER_ZERO_FLAG_EN adds out_zero_o.
module pipelined_barrel_shifter #(
    parameter int DW          = 8,
    parameter int MAX_SHIFT   = DW - 1,
    parameter int LVL_PER_REG = 1,
    parameter int TAG_W       = 4,
    localparam int LVLS       = $clog2(MAX_SHIFT + 1),
    localparam int NSEG       = (LVLS + LVL_PER_REG - 1) / LVL_PER_REG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [DW-1:0]    in_data_i,
    input  logic [LVLS-1:0]  in_amt_i,
    input  logic [2:0]       in_mode_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [DW-1:0]    out_data_o,
    output logic [TAG_W-1:0] out_tag_o
`ifdef SHIFTER_ZERO_FLAG_EN
    ,
    output logic             out_zero_o
`endif
);

    localparam logic [2:0] M_ROL = 3'b000;
    localparam logic [2:0] M_ROR = 3'b001;
    localparam logic [2:0] M_SLL = 3'b010;
    localparam logic [2:0] M_SRL = 3'b011;
    localparam logic [2:0] M_SRA = 3'b100;

    if (MAX_SHIFT >= DW || MAX_SHIFT < 1 || LVL_PER_REG < 1) begin : g_bad_cfg
        $fatal(1, "pipelined_barrel_shifter: illegal MAX_SHIFT/LVL_PER_REG for DW");
    end

    function automatic logic [DW-1:0] shift_lvl(input logic [DW-1:0] d, input int sh,
                                                 input logic [2:0] mode, input logic sign);
        logic [2*DW-1:0] wide;
        logic [DW-1:0]   r;
        wide = '0;
        r    = d;
        case (mode)
            M_ROL: begin wide = {d, d} << sh; r = wide[2*DW-1:DW]; end
            M_ROR: begin wide = {d, d} >> sh; r = wide[DW-1:0];    end
            M_SLL: r = d << sh;
            M_SRL: r = d >> sh;
            // Fill comes from the original operand's MSB, carried alongside the partial result.
            M_SRA: begin wide = {{DW{sign}}, d} >> sh; r = wide[DW-1:0]; end
            default: r = d;
        endcase
        return r;
    endfunction

    logic             vld_q  [NSEG];
    logic             vld_d  [NSEG];
    logic [DW-1:0]    data_q [NSEG];
    logic [DW-1:0]    data_d [NSEG];
    logic [LVLS-1:0]  amt_q  [NSEG];
    logic [LVLS-1:0]  amt_d  [NSEG];
    logic [2:0]       mode_q [NSEG];
    logic [2:0]       mode_d [NSEG];
    logic [TAG_W-1:0] tag_q  [NSEG];
    logic [TAG_W-1:0] tag_d  [NSEG];
    logic             sign_q [NSEG];
    logic             sign_d [NSEG];

    logic             en       [NSEG];
    logic             src_vld  [NSEG];
    logic [DW-1:0]    src_data [NSEG];
    logic [LVLS-1:0]  src_amt  [NSEG];
    logic [2:0]       src_mode [NSEG];
    logic [TAG_W-1:0] src_tag  [NSEG];
    logic             src_sign [NSEG];

    // A segment can load when it or any register downstream of it has a free slot.
    always_comb begin
        for (int k = 0; k < NSEG; k++) begin
            en[k] = out_ready_i;
            for (int j = k; j < NSEG; j++) begin
                en[k] = en[k] || !vld_q[j];
            end
        end
    end

    assign in_ready_o = !rst && en[0];

    for (genvar k = 0; k < NSEG; k++) begin : g_src
        if (k == 0) begin : g_first
            assign src_vld[k]  = in_valid_i && in_ready_o;
            assign src_data[k] = in_data_i;
            assign src_amt[k]  = in_amt_i;
            assign src_mode[k] = in_mode_i;
            assign src_tag[k]  = in_tag_i;
            assign src_sign[k] = in_data_i[DW-1];
        end else begin : g_next
            assign src_vld[k]  = vld_q[k-1];
            assign src_data[k] = data_q[k-1];
            assign src_amt[k]  = amt_q[k-1];
            assign src_mode[k] = mode_q[k-1];
            assign src_tag[k]  = tag_q[k-1];
            assign src_sign[k] = sign_q[k-1];
        end
    end

    always_comb begin
        logic [DW-1:0] d;
        d = '0;
        for (int k = 0; k < NSEG; k++) begin
            vld_d[k]  = vld_q[k];
            data_d[k] = data_q[k];
            amt_d[k]  = amt_q[k];
            mode_d[k] = mode_q[k];
            tag_d[k]  = tag_q[k];
            sign_d[k] = sign_q[k];
            if (en[k]) begin
                vld_d[k] = src_vld[k];
                // Payload only moves with a valid op, so idle registers keep their last value.
                if (src_vld[k]) begin
                    d = src_data[k];
                    for (int s = 0; s < LVLS; s++) begin
                        if ((s / LVL_PER_REG) == k && src_amt[k][s]) begin
                            d = shift_lvl(d, 1 << s, src_mode[k], src_sign[k]);
                        end
                    end
                    data_d[k] = d;
                    amt_d[k]  = src_amt[k];
                    mode_d[k] = src_mode[k];
                    tag_d[k]  = src_tag[k];
                    sign_d[k] = src_sign[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NSEG; k++) begin
            if (rst) begin
                vld_q[k]  <= 1'b0;
                data_q[k] <= '0;
                amt_q[k]  <= '0;
                mode_q[k] <= '0;
                tag_q[k]  <= '0;
                sign_q[k] <= 1'b0;
            end else begin
                vld_q[k]  <= vld_d[k];
                data_q[k] <= data_d[k];
                amt_q[k]  <= amt_d[k];
                mode_q[k] <= mode_d[k];
                tag_q[k]  <= tag_d[k];
                sign_q[k] <= sign_d[k];
            end
        end
    end

    assign out_valid_o = vld_q[NSEG-1];
    assign out_data_o  = data_q[NSEG-1];
    assign out_tag_o   = tag_q[NSEG-1];

`ifdef SHIFTER_ZERO_FLAG_EN
    logic zero_q;
    logic zero_d;

    always_comb begin
        zero_d = zero_q;
        if (en[NSEG-1] && src_vld[NSEG-1]) begin
            zero_d = (data_d[NSEG-1] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign out_zero_o = zero_q;
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter: directed vectors, streaming, stall and mid-flight reset.
module tb_pipelined_barrel_shifter;

    localparam int DW    = 8;
    localparam int TAG_W = 4;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [DW-1:0]    in_data_i;
    logic [AW-1:0]    in_amt_i;
    logic [2:0]       in_mode_i;
    logic [TAG_W-1:0] in_tag_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [DW-1:0]    out_data_o;
    logic [TAG_W-1:0] out_tag_o;
`ifdef SHIFTER_ZERO_FLAG_EN
    logic             out_zero_o;
`endif

    pipelined_barrel_shifter dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_amt_i    (in_amt_i),
        .in_mode_i   (in_mode_i),
        .in_tag_i    (in_tag_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_tag_o   (out_tag_o)
`ifdef SHIFTER_ZERO_FLAG_EN
        ,
        .out_zero_o  (out_zero_o)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    logic [DW-1:0]    q_data [$];
    logic [TAG_W-1:0] q_tag  [$];
    int               q_hs   [$];
    bit               q_lat  [$];
    bit               q_zero [$];

    bit               flush_watch = 1'b0;
    bit               prev_stall  = 1'b0;
    logic [DW-1:0]    prev_data;
    logic [TAG_W-1:0] prev_tag;
    logic             prev_zero;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one op and hold it until accepted; the expectation is queued just before the handshake edge.
    task automatic send(input logic [7:0] d, input logic [2:0] amt, input logic [2:0] mode,
                        input logic [3:0] tag, input logic [7:0] exp, input bit zero, input bit lat);
        int n;
        n = 0;
        @(posedge clk); #1;
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_amt_i   = amt;
        in_mode_i  = mode;
        in_tag_i   = tag;
        @(negedge clk);
        while (!in_ready_o && n < 50) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        if (!in_ready_o) begin
            check("send_accept_timeout", 32'(in_ready_o), 32'd1);
            in_valid_i = 1'b0;
            return;
        end
        q_data.push_back(exp);
        q_tag.push_back(tag);
        q_hs.push_back(cyc);
        q_lat.push_back(lat);
        q_zero.push_back(zero);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q_data.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", 32'(q_data.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_valid", 32'(out_valid_o), 32'd1);
                check("stall_hold_data", 32'(out_data_o), 32'(prev_data));
                check("stall_hold_tag", 32'(out_tag_o), 32'(prev_tag));
`ifdef SHIFTER_ZERO_FLAG_EN
                check("stall_hold_zero", 32'(out_zero_o), 32'(prev_zero));
`endif
            end
            if (out_valid_o && out_ready_i) begin
                if (flush_watch && out_tag_o >= 4'd13) begin
                    check("flushed_tag_seen", 32'(out_tag_o), 32'd1);
                end
                if (q_data.size() == 0) begin
                    check("unexpected_output_tag", 32'(out_tag_o), 32'hFFFF_FFFF);
                end else begin
                    check("result_tag", 32'(out_tag_o), 32'(q_tag[0]));
                    check("result_data", 32'(out_data_o), 32'(q_data[0]));
                    if (q_lat[0]) check("latency", 32'(cyc - q_hs[0]), 32'd3);
`ifdef SHIFTER_ZERO_FLAG_EN
                    check("result_zero", 32'(out_zero_o), 32'(q_zero[0]));
`endif
                    void'(q_data.pop_front());
                    void'(q_tag.pop_front());
                    void'(q_hs.pop_front());
                    void'(q_lat.pop_front());
                    void'(q_zero.pop_front());
                end
            end
            prev_stall = out_valid_o && !out_ready_i;
            prev_data  = out_data_o;
            prev_tag   = out_tag_o;
`ifdef SHIFTER_ZERO_FLAG_EN
            prev_zero  = out_zero_o;
`else
            prev_zero  = 1'b0;
`endif
        end
    end

    // Directed vectors: {data, amt, mode, expected}
    logic [7:0] dv_data [16] = '{8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h41, 8'h81, 8'h81,
                                 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h01};
    logic [2:0] dv_amt  [16] = '{3'd1, 3'd1, 3'd3, 3'd3, 3'd3, 3'd3, 3'd0, 3'd0,
                                 3'd0, 3'd0, 3'd0, 3'd5, 3'd5, 3'd5, 3'd7, 3'd1};
    logic [2:0] dv_mode [16] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b100, 3'b000, 3'b001,
                                 3'b010, 3'b011, 3'b100, 3'b110, 3'b101, 3'b111, 3'b010, 3'b011};
    logic [7:0] dv_exp  [16] = '{8'h03, 8'hC0, 8'h08, 8'h10, 8'hF0, 8'h08, 8'h81, 8'h81,
                                 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h80, 8'h00};

    logic [7:0] st_data [10] = '{8'h01, 8'h01, 8'h80, 8'h01, 8'h0F, 8'hFF, 8'hFF, 8'h80, 8'h7F, 8'hA5};
    logic [2:0] st_amt  [10] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd4, 3'd4, 3'd7, 3'd7, 3'd7, 3'd7};
    logic [2:0] st_mode [10] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b001,
                                 3'b010, 3'b011, 3'b100, 3'b100, 3'b000};
    logic [7:0] st_exp  [10] = '{8'h01, 8'h02, 8'h01, 8'h80, 8'hF0, 8'hF0, 8'h01, 8'hFF, 8'h00, 8'hD2};

    // SLL of 0x11 by the acceptance index
    logic [7:0] sl_exp  [5]  = '{8'h11, 8'h22, 8'h44, 8'h88, 8'h10};

    initial begin
        int acc;
        rst         = 1'b1;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        in_amt_i    = '0;
        in_mode_i   = '0;
        in_tag_i    = '0;
        out_ready_i = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid_o), 32'd0);
        check("reset_out_data", 32'(out_data_o), 32'd0);
        check("reset_out_tag", 32'(out_tag_o), 32'd0);
        check("reset_in_ready_low", 32'(in_ready_o), 32'd0);
`ifdef SHIFTER_ZERO_FLAG_EN
        check("reset_out_zero", 32'(out_zero_o), 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", 32'(in_ready_o), 32'd1);

        for (int i = 0; i < 16; i++) begin
            send(dv_data[i], dv_amt[i], dv_mode[i], 4'(i), dv_exp[i], dv_exp[i] == 8'h00, 1'b1);
        end
        idle();
        drain();

        for (int i = 0; i < 10; i++) begin
            send(st_data[i], st_amt[i], st_mode[i], 4'(i), st_exp[i], st_exp[i] == 8'h00, 1'b1);
        end
        idle();
        drain();

        @(posedge clk); #1;
        out_ready_i = 1'b0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            in_valid_i = 1'b1;
            in_data_i  = 8'h11;
            in_amt_i   = 3'(acc);
            in_mode_i  = 3'b010;
            in_tag_i   = 4'(8 + acc);
            @(negedge clk);
            if (in_ready_o && acc < 5) begin
                q_data.push_back(sl_exp[acc]);
                q_tag.push_back(4'(8 + acc));
                q_hs.push_back(cyc);
                q_lat.push_back(1'b0);
                q_zero.push_back(1'b0);
                acc++;
            end
        end
        check("stall_accept_count", 32'(acc), 32'd3);
        check("stall_in_ready_low", 32'(in_ready_o), 32'd0);
        @(posedge clk); #1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        drain();

        @(posedge clk); #1;
        out_ready_i = 1'b0;
        send(8'h81, 3'd1, 3'b000, 4'd13, 8'h03, 1'b0, 1'b0);
        send(8'h81, 3'd1, 3'b001, 4'd14, 8'hC0, 1'b0, 1'b0);
        send(8'h81, 3'd3, 3'b010, 4'd15, 8'h08, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst        = 1'b1;
        in_valid_i = 1'b1;
        in_tag_i   = 4'd13;
        q_data.delete();
        q_tag.delete();
        q_hs.delete();
        q_lat.delete();
        q_zero.delete();
        @(negedge clk);
        check("rst_in_ready_low", 32'(in_ready_o), 32'd0);
        @(posedge clk); #1;
        rst         = 1'b0;
        in_valid_i  = 1'b0;
        flush_watch = 1'b1;
        @(negedge clk);
        check("flush_out_valid", 32'(out_valid_o), 32'd0);
        check("flush_out_data", 32'(out_data_o), 32'd0);
        check("flush_out_tag", 32'(out_tag_o), 32'd0);
        check("flush_in_ready", 32'(in_ready_o), 32'd1);
        @(posedge clk); #1;
        out_ready_i = 1'b1;
        send(8'h81, 3'd1, 3'b001, 4'd1, 8'hC0, 1'b0, 1'b1);
        send(8'h41, 3'd3, 3'b100, 4'd2, 8'h08, 1'b0, 1'b1);
        idle();
        drain();
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
